multicycle_ctrl: RTL

Multi-cycle sequencer for the RV32 core. It drives instruction fetch, instruction-register load, the data-memory access phase, register-file write enable and PC update, using the classification bits produced by the combinational instruction decoder. It sits between the instruction/data memory ports and the datapath. It owns no data, only control, retire counting and memory-timeout fault detection.

---
 rtl/multicycle_ctrl_pkg.sv | 64 ++++++
 rtl/multicycle_ctrl_if.sv | 17 +
 rtl/multicycle_ctrl_mem_wait_timer.sv | 30 +++
 rtl/multicycle_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings,
// writeback-source codes, the bundle of registered strobes and the helper
// that maps a state to the strobes it drives.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    CTRL_ST_IDLE   = 3'd0,
    CTRL_ST_FETCH  = 3'd1,
    CTRL_ST_DECODE = 3'd2,
    CTRL_ST_EXEC   = 3'd3,
    CTRL_ST_MEM    = 3'd4,
    CTRL_ST_WB     = 3'd5,
    CTRL_ST_FAULT  = 3'd6
  } ctrl_state_e;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2
  } wb_sel_e;

  // Every Moore strobe of the controller, registered as one word.
  typedef struct packed {
    logic    imem_req;
    logic    dmem_req;
    logic    dmem_we;
    logic    rf_we;
    wb_sel_e wb_sel;
    logic    pc_write;
    logic    pc_src;
    logic    retire;
    logic    fault;
  } strobes_t;

  // Strobes driven while sitting in state s. The dec_* arguments only matter
  // for MEM and WB, where the decoder outputs are guaranteed stable.
  function automatic strobes_t strobes_for(input ctrl_state_e s,
                                           input logic mem_read,
                                           input logic mem_write,
                                           input logic is_jump,
                                           input logic we);
    strobes_t o;
    o = '0;
    case (s)
      CTRL_ST_FETCH: o.imem_req = 1'b1;
      CTRL_ST_MEM: begin
        o.dmem_req = 1'b1;
        o.dmem_we  = mem_write;
      end
      CTRL_ST_WB: begin
        o.rf_we    = we;
        o.pc_write = 1'b1;
        o.pc_src   = is_jump;
        o.retire   = 1'b1;
        // Jump link value has priority over load data.
        o.wb_sel   = is_jump ? WB_SEL_PC4 : (mem_read ? WB_SEL_MEM : WB_SEL_ALU);
      end
      CTRL_ST_FAULT: o.fault = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction- and data-memory handshake bundle.
//   imem_req / imem_ready : instruction fetch request and word-valid
//   dmem_req / dmem_we    : data access request and write qualifier
//   dmem_ready            : data access complete
// master = controller side, slave = memory side.
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (output imem_req, dmem_req, dmem_we,
                  input  imem_ready, dmem_ready);
  modport slave  (input  imem_req, dmem_req, dmem_we,
                  output imem_ready, dmem_ready);
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// mem_wait_timer: 8-bit wait counter shared by the FETCH and MEM states.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : force the count to zero (has priority over inc)
//   inc        : add one this cycle
//   tc         : count has reached MEM_TIMEOUT
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [7:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
  end

  // The FSM leaves the waiting state as soon as tc is seen without ready,
  // so the count never runs past MEM_TIMEOUT.
  assign tc = (cnt == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the RV32 core.
//   clk, rst_n       : clock, asynchronous active-low reset
//   run              : execute while high, stop at the next instruction boundary
//   mem              : instruction/data memory handshakes (master modport)
//   dec_*            : classification bits from the instruction decoder
//   ir_load          : IR load strobe (FETCH & imem_ready)
//   rf_we, wb_sel    : register-file write strobe and writeback source
//   pc_write, pc_src : PC update strobe and source (0 = PC+4, 1 = jump)
//   retire, instret  : completion pulse and retired-instruction count
//   fault            : sticky memory-timeout fault
//   state            : current FSM state for debug
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  multicycle_ctrl_if.master     mem,
  input  logic                  dec_mem_read,
  input  logic                  dec_mem_write,
  input  logic                  dec_is_jump,
  input  logic                  dec_we,
  output logic                  ir_load,
  output logic                  rf_we,
  output logic [1:0]            wb_sel,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  retire,
  output logic [CNT_W-1:0]      instret,
  output logic                  fault,
  output logic [2:0]            state
);

  ctrl_state_e st, nxt;
  strobes_t    outs;
  logic        waiting, rdy, tmr_tc;

  // The timer runs only while a request is outstanding; everywhere else it
  // is held clear, so it always reads zero on entry to FETCH or MEM.
  assign waiting = (st == CTRL_ST_FETCH) || (st == CTRL_ST_MEM);
  assign rdy     = (st == CTRL_ST_FETCH) ? mem.imem_ready : mem.dmem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!waiting || rdy),
    .inc   (waiting && !rdy),
    .tc    (tmr_tc)
  );

  // NOTE: nxt gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    nxt = st;
    case (st)
      CTRL_ST_IDLE:   if (run) nxt = CTRL_ST_FETCH;
      // Ready is tested first so it wins over a same-cycle timeout.
      CTRL_ST_FETCH:  if (mem.imem_ready) nxt = CTRL_ST_DECODE;
                      else if (tmr_tc)    nxt = CTRL_ST_FAULT;
      CTRL_ST_DECODE: nxt = CTRL_ST_EXEC;
      CTRL_ST_EXEC:   nxt = (dec_mem_read || dec_mem_write) ? CTRL_ST_MEM : CTRL_ST_WB;
      CTRL_ST_MEM:    if (mem.dmem_ready) nxt = CTRL_ST_WB;
                      else if (tmr_tc)    nxt = CTRL_ST_FAULT;
      CTRL_ST_WB:     nxt = run ? CTRL_ST_FETCH : CTRL_ST_IDLE;
      CTRL_ST_FAULT:  nxt = CTRL_ST_FAULT;
      default:        nxt = CTRL_ST_IDLE;  // encoding 7 recovers
    endcase
  end

  // Strobes are registered from the state being entered, so each output is a
  // clean flop that is valid for exactly the cycles spent in that state.
  // NOTE: the async reset clears every control flop, so requests drop the
  // moment rst_n falls rather than at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= CTRL_ST_IDLE;
      outs    <= '0;
      instret <= '0;
    end else begin
      st   <= nxt;
      outs <= strobes_for(nxt, dec_mem_read, dec_mem_write, dec_is_jump, dec_we);
      if (st == CTRL_ST_WB) instret <= instret + CNT_W'(1);
    end
  end

  assign mem.imem_req = outs.imem_req;
  assign mem.dmem_req = outs.dmem_req;
  assign mem.dmem_we  = outs.dmem_we;
  assign rf_we        = outs.rf_we;
  assign wb_sel       = outs.wb_sel;
  assign pc_write     = outs.pc_write;
  assign pc_src       = outs.pc_src;
  assign retire       = outs.retire;
  assign fault        = outs.fault;
  assign state        = st;

  // The only Mealy output: IR captures the word in the cycle it is valid.
  assign ir_load = (st == CTRL_ST_FETCH) && mem.imem_ready;

endmodule
